// File: rtl/pulse_stretcher.sv
// Turns single-cycle internal events into fixed-width pulses on a physical pin,
// queueing events in a saturating counter. Define PULSE_STRETCHER_ACTIVE_LOW_EN for a low-going pin.
module pulse_stretcher #(
    parameter int HIGH_CYCLES = 1000000,
    parameter int LOW_CYCLES  = 500000,
    parameter int MAX_PENDING = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             event_in,
    input  logic                             clear_dropped,
    output logic                             pin_out,
    output logic                             busy,
    output logic [$clog2(MAX_PENDING+1)-1:0] pending_count,
    output logic                             dropped
);
    localparam int TMAX = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int PW   = $clog2(MAX_PENDING + 1);

`ifdef PULSE_STRETCHER_ACTIVE_LOW_EN
    localparam logic PIN_IDLE = 1'b1;
`else
    localparam logic PIN_IDLE = 1'b0;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_t;

    state_t         state_reg, state_next;
    logic [TW-1:0]  timer_reg, timer_next;
    logic [PW-1:0]  pending_reg, pending_next;
    logic           dropped_reg, dropped_next;
    logic           pin_reg, pin_next;
    logic           bypass, consume, enq, overflow;
    logic [PW:0]    pend_sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            timer_reg   <= '0;
            pending_reg <= '0;
            dropped_reg <= 1'b0;
            pin_reg     <= PIN_IDLE;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            pending_reg <= pending_next;
            dropped_reg <= dropped_next;
            pin_reg     <= pin_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg + TW'(1);
        bypass     = 1'b0;
        consume    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                timer_next = '0;
                if (event_in) begin
                    state_next = ST_HIGH;
                    bypass     = 1'b1;
                end
            end
            ST_HIGH: begin
                if (timer_reg == TW'(HIGH_CYCLES - 1)) begin
                    state_next = ST_LOW;
                    timer_next = '0;
                end
            end
            ST_LOW: begin
                // The low gap always runs to completion; queued events win over a same-cycle event_in.
                if (timer_reg == TW'(LOW_CYCLES - 1)) begin
                    timer_next = '0;
                    if (pending_reg != '0) begin
                        state_next = ST_HIGH;
                        consume    = 1'b1;
                    end else if (event_in) begin
                        state_next = ST_HIGH;
                        bypass     = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                timer_next = '0;
            end
        endcase

        enq          = event_in & ~bypass;
        pend_sum     = {1'b0, pending_reg} + (PW+1)'(enq) - (PW+1)'(consume);
        overflow     = (pend_sum > (PW+1)'(MAX_PENDING));
        pending_next = overflow ? PW'(MAX_PENDING) : pend_sum[PW-1:0];
        if (overflow)
            dropped_next = 1'b1;
        else if (clear_dropped)
            dropped_next = 1'b0;
        else
            dropped_next = dropped_reg;
    end

    always_comb begin
        pin_next = (state_next == ST_HIGH) ? ~PIN_IDLE : PIN_IDLE;
        busy     = (state_reg != ST_IDLE) || (pending_reg != '0);
    end

    assign pin_out       = pin_reg;
    assign pending_count = pending_reg;
    assign dropped       = dropped_reg;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench for pulse_stretcher with HIGH=4, LOW=3, MAX_PENDING=2;
// expected per-cycle outputs are queued as stimulus is applied.
module tb_pulse_stretcher;
    localparam int HC = 4;
    localparam int LC = 3;
    localparam int MP = 2;
`ifdef PULSE_STRETCHER_ACTIVE_LOW_EN
    localparam logic ACT = 1'b0;
`else
    localparam logic ACT = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       event_in = 1'b0;
    logic       clear_dropped = 1'b0;
    logic       pin_out, busy, dropped;
    logic [1:0] pending_count;

    typedef struct packed {
        logic       pin;
        logic       busy;
        logic [1:0] pend;
        logic       drop;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    pulse_stretcher #(.HIGH_CYCLES(HC), .LOW_CYCLES(LC), .MAX_PENDING(MP)) dut (
        .clk(clk), .reset(reset), .event_in(event_in), .clear_dropped(clear_dropped),
        .pin_out(pin_out), .busy(busy), .pending_count(pending_count), .dropped(dropped)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic obs_t mk(input bit high, input bit b, input int p, input bit d);
        obs_t o;
        o.pin  = high ? ACT : ~ACT;
        o.busy = b;
        o.pend = 2'(p);
        o.drop = d;
        return o;
    endfunction

    function automatic obs_t observed();
        return {pin_out, busy, pending_count, dropped};
    endfunction

    // Drive one cycle of inputs and move to 1ns past the closing edge.
    task automatic tick(input logic ev, input logic clr, input obs_t e);
        exp_q.push_back(e);
        event_in      = ev;
        clear_dropped = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        event_in      = 1'b0;
        clear_dropped = 1'b0;
        reset         = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e, got;
        reset = 1'b1;
        #3;
        exp_q.push_back(mk(0, 0, 0, 0));
        #1;
        got = observed();
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL reset_state got %b exp %b (pin,busy,pend[1:0],drop)", got, e);
        end
        do_reset();
    endtask

    task automatic test_single();
        obs_t e, got;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            int k = c + 1;
            tick(c == 0, 1'b0, mk(k >= 1 && k <= 4, k <= 7, 0, 0));
            got = observed();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL single cycle %0d got %b exp %b", k, got, e);
            end
        end
    endtask

    task automatic test_queue_overflow();
        obs_t e, got;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            int k = c + 1;
            int p;
            bit hi;
            p  = (k == 3) ? 1 : (k >= 4 && k <= 7) ? 2 : (k >= 8 && k <= 14) ? 1 : 0;
            hi = (k >= 1 && k <= 4) || (k >= 8 && k <= 11) || (k >= 15 && k <= 18);
            tick(c == 0 || c == 2 || c == 3 || c == 4, 1'b0, mk(hi, k <= 21, p, k >= 5));
            got = observed();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL queue cycle %0d got %b exp %b", k, got, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, got;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            int k = c + 1;
            tick(c == 0 || c == 7, 1'b0,
                 mk((k >= 1 && k <= 4) || (k >= 8 && k <= 11), k <= 14, 0, 0));
            got = observed();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL back_to_back cycle %0d got %b exp %b", k, got, e);
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        obs_t e, got;
        do_reset();
        tick(1'b1, 1'b0, mk(1, 1, 0, 0));
        tick(1'b1, 1'b0, mk(1, 1, 1, 0));
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (i == 1) begin
                got = observed();
                if (got !== e) begin
                    errors++;
                    $display("FAIL mid_reset pre-reset got %b exp %b", got, e);
                end
            end
        end
        event_in = 1'b0;
        #2;
        reset = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 0));
        #1;
        got = observed();
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL mid_reset async got %b exp %b", got, e);
        end
        @(negedge clk);
        reset = 1'b0;
        tick(1'b1, 1'b0, mk(1, 1, 0, 0));
        got = observed();
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL mid_reset restart got %b exp %b", got, e);
        end
    endtask

    task automatic test_dropped();
        obs_t e, got;
        logic ev_t  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic clr_t [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic hi_t  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        int   pend_t[8] = '{0, 1, 2, 2, 2, 2, 2, 2};
        logic drop_t[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            tick(ev_t[c], clr_t[c], mk(hi_t[c], 1'b1, pend_t[c], drop_t[c]));
            got = observed();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL dropped cycle %0d got %b exp %b", c + 1, got, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_queue_overflow();
        test_back_to_back();
        test_reset_mid_pulse();
        test_dropped();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Output-side counterpart to the input switch debouncer. The debouncer turns a noisy physical pin into a clean internal level; this block turns clean internal single-cycle events into human- or device-visible pulses on a physical output pin (LED, buzzer, relay).
- Every accepted event produces one output pulse of guaranteed minimum high time, followed by a guaranteed minimum low gap.
- Events arriving while a pulse is in progress are queued in a saturating pending counter. Events beyond capacity are dropped and flagged.

Parameters:
- HIGH_CYCLES, default 1000000: output-high duration per pulse, in clk cycles. Must be >= 1.
- LOW_CYCLES, default 500000: mandatory low gap after each pulse, in clk cycles. Must be >= 1.
- MAX_PENDING, default 3: maximum queued events. Must be >= 1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- event_in  input  1  each clk cycle sampled high counts as exactly one event
- clear_dropped  input  1  synchronous clear of dropped flag
- pin_out  output  1  registered drive to physical pin, active-high by default
- busy  output  1  high when state != IDLE or pending_count != 0
- pending_count  output  $clog2(MAX_PENDING+1)  events queued, not yet started
- dropped  output  1  sticky flag: at least one event was discarded

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE; timer, pending_count, dropped all 0.
  - pin_out = 0, busy = 0 immediately, independent of clk.
  - Reset mid-pulse aborts the pulse; queued events are lost.
- States: IDLE, HIGH, LOW. pin_out is registered and equals (state == HIGH).
- Timer:
  - Width $clog2(max(HIGH_CYCLES, LOW_CYCLES)+1).
  - Loads 0 on entry to HIGH or LOW and increments each cycle.
  - Phase ends on the cycle timer == N-1, where N is the phase length.
- "start" condition at a decision point: pending_count != 0 OR event_in.
- IDLE:
  - If event_in: go to HIGH at that edge (bypass; event is consumed, not queued).
  - Latency from event_in sampled high to pin_out = 1 is one cycle.
- HIGH:
  - pin_out = 1 for exactly HIGH_CYCLES cycles, then go to LOW.
- LOW:
  - pin_out = 0 for exactly LOW_CYCLES cycles.
  - On the final LOW cycle, if start: go to HIGH and consume one event. The queued event is taken first; if pending == 0, the event_in of that cycle is consumed by bypass.
  - Otherwise go to IDLE.
  - LOW is never skipped or shortened.
- Pending arithmetic, per cycle:
  - Let consume = 1 when a queued event starts a pulse this cycle.
  - Let enq = 1 when event_in is high and not consumed by bypass.
  - pending_next = pending + enq - consume.
  - If pending + enq - consume > MAX_PENDING, hold at MAX_PENDING and set dropped.
  - Simultaneous enqueue and consume at full capacity leaves pending at MAX_PENDING with no drop.
- dropped:
  - Set on overflow.
  - Cleared by clear_dropped only when no overflow occurs in the same cycle; overflow wins.
- busy is combinational from registered state and pending.
- Guaranteed properties:
  - pin_out never shows a high run other than exactly HIGH_CYCLES.
  - pin_out never shows a low run between pulses shorter than LOW_CYCLES.

Optional Feature:
- Macro PULSE_STRETCHER_ACTIVE_LOW_EN.
- Defined: pin_out is driven as NOT(state == HIGH). Reset value of pin_out is 1, idle level is 1, and pulses are low-going. All timing is identical.
- Undefined: active-high behaviour as above, with reset value 0.
- No other outputs change.

Test Plan (HIGH_CYCLES=4, LOW_CYCLES=3, MAX_PENDING=2):
- Single event_in at cycle 0 after reset -> pin_out = 1 cycles 1-4, 0 cycles 5-7; IDLE with busy = 0 from cycle 8; pending stays 0.
- event_in at cycles 0, 2, 3, 4 -> pending goes 0, 1, 2, 2 and dropped = 1 at cycle 5. Pulses high at 1-4, 8-11, 15-18; total 3 pulses; busy = 0 from cycle 22.
- event_in held high on final LOW cycle (cycle 7) with pending = 0 -> pin_out = 1 at cycle 8; pending stays 0 (bypass consumed).
- Reset asserted mid-HIGH at cycle 2 with pending = 1 -> pin_out, pending, busy = 0 asynchronously. The next event_in gives pin_out high one cycle later.
- dropped = 1, clear_dropped pulsed with no overflow -> dropped = 0 next cycle. clear_dropped concurrent with overflow -> dropped stays 1.
- Build with PULSE_STRETCHER_ACTIVE_LOW_EN, single event at cycle 0 -> pin_out = 1 in reset, 0 cycles 1-4, 1 thereafter.
